// File: rtl/fp32_pkg.sv
// Shared binary32 constants, operand class encodings and flag indices
// for the multiplier round/pack datapath.
package fp32_pkg;

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'b00,
    CLS_ZERO   = 2'b01,
    CLS_INF    = 2'b10,
    CLS_NAN    = 2'b11
  } cls_e;

  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a stored mantissa with guard/sticky bits.
// Reports the carry out of the mantissa so the caller can bump the exponent.
module fp_round_rne #(
  parameter int M_WIDTH = 23
) (
  input  logic [M_WIDTH-1:0] i_mant,
  input  logic               i_g,
  input  logic               i_s,
  output logic [M_WIDTH-1:0] o_mant,
  output logic               o_carry,
  output logic               o_inexact
);

  logic w_up;

  assign w_up = i_g & (i_s | i_mant[0]);

  assign {o_carry, o_mant} =
    {1'b0, i_mant} + {{M_WIDTH{1'b0}}, w_up};

  assign o_inexact = i_g | i_s;

endmodule

// File: rtl/fp32_mul_round_pack.sv
// Normalize, RNE-round and pack a raw fp32 significand product.
// Two-stage valid/ready pipeline: normalize, then round/pack.
module fp32_mul_round_pack
  import fp32_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int E_WIDTH = 8,
  parameter int M_WIDTH = 23,
  parameter int P_WIDTH = 2 * (M_WIDTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic signed [E_WIDTH+1:0] in_exp,
  input  logic [P_WIDTH-1:0]        in_prod,
  input  logic [1:0]                a_cls,
  input  logic [1:0]                b_cls,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [D_WIDTH-1:0]        out_result,
  output logic [3:0]                out_flags
);

  localparam int XW = E_WIDTH + 2;

  logic w_s1_adv;
  logic w_s2_adv;
  logic r1_valid;
  logic r2_valid;

  assign w_s2_adv  = !r2_valid || out_ready;
  assign w_s1_adv  = !r1_valid || w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign out_valid = r2_valid;

  logic                   w_hi;
  logic [M_WIDTH-1:0]     w_mant;
  logic                   w_g;
  logic                   w_s;
  logic signed [XW-1:0]   w_exp;

  assign w_hi = in_prod[P_WIDTH-1];

  assign w_mant = w_hi ? in_prod[P_WIDTH-2 -: M_WIDTH]
                       : in_prod[P_WIDTH-3 -: M_WIDTH];

  assign w_g = w_hi ? in_prod[P_WIDTH-M_WIDTH-2]
                    : in_prod[P_WIDTH-M_WIDTH-3];

  assign w_s = w_hi ? |in_prod[P_WIDTH-M_WIDTH-3:0]
                    : |in_prod[P_WIDTH-M_WIDTH-4:0];

  assign w_exp = in_exp + $signed({{(XW-1){1'b0}}, w_hi});

  logic w_any_nan;
  logic w_any_inf;
  logic w_any_zero;
  logic w_inf_zero;
  logic w_inf_only;
  logic w_zero_only;
  cls_e w_cls;
  logic w_inv;

  assign w_any_nan  = (a_cls == CLS_NAN) || (b_cls == CLS_NAN);
  assign w_any_inf  = (a_cls == CLS_INF) || (b_cls == CLS_INF);
  assign w_any_zero = (a_cls == CLS_ZERO) || (b_cls == CLS_ZERO);

  // Mutually exclusive so the one-hot decode below is truly unique.
  assign w_inf_zero  = !w_any_nan && w_any_inf && w_any_zero;
  assign w_inf_only  = !w_any_nan && w_any_inf && !w_any_zero;
  assign w_zero_only = !w_any_nan && w_any_zero && !w_any_inf;

  always_comb begin
    w_cls = CLS_NORMAL;
    w_inv = 1'b0;
    unique case (1'b1)
      w_any_nan:   w_cls = CLS_NAN;
      w_inf_zero: begin
        w_cls = CLS_NAN;
        w_inv = 1'b1;
      end
      w_inf_only:  w_cls = CLS_INF;
      w_zero_only: w_cls = CLS_ZERO;
      default:     w_cls = CLS_NORMAL;
    endcase
  end

  logic                 r1_sign;
  logic signed [XW-1:0] r1_exp;
  logic [M_WIDTH-1:0]   r1_mant;
  logic                 r1_g;
  logic                 r1_s;
  cls_e                 r1_cls;
  logic                 r1_inv;

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid <= 1'b0;
      r1_sign  <= 1'b0;
      r1_exp   <= '0;
      r1_mant  <= '0;
      r1_g     <= 1'b0;
      r1_s     <= 1'b0;
      r1_cls   <= CLS_NORMAL;
      r1_inv   <= 1'b0;
    end else if (w_s1_adv) begin
      r1_valid <= in_valid;
      if (in_valid) begin
        r1_sign <= in_sign;
        r1_exp  <= w_exp;
        r1_mant <= w_mant;
        r1_g    <= w_g;
        r1_s    <= w_s;
        r1_cls  <= w_cls;
        r1_inv  <= w_inv;
      end
    end
  end

  logic [M_WIDTH-1:0]   w_mant_rnd;
  logic                 w_carry;
  logic                 w_inx;
  logic signed [XW-1:0] w_exp_rnd;

  fp_round_rne #(
    .M_WIDTH(M_WIDTH)
  ) u_rnd (
    .i_mant   (r1_mant),
    .i_g      (r1_g),
    .i_s      (r1_s),
    .o_mant   (w_mant_rnd),
    .o_carry  (w_carry),
    .o_inexact(w_inx)
  );

  assign w_exp_rnd = r1_exp + $signed({{(XW-1){1'b0}}, w_carry});

  logic [D_WIDTH-1:0] w_res;
  logic [3:0]         w_flg;

  always_comb begin
    w_res = '0;
    w_flg = '0;
    unique case (r1_cls)
      CLS_NAN: begin
        w_res          = QNAN;
        w_flg[FLG_INV] = r1_inv;
      end
      CLS_INF:
        w_res = {r1_sign, {E_WIDTH{1'b1}}, {M_WIDTH{1'b0}}};
      CLS_ZERO:
        w_res = {r1_sign, {(D_WIDTH-1){1'b0}}};
      CLS_NORMAL: begin
        if (w_exp_rnd >= EXP_MAX) begin
          w_res = {r1_sign, {E_WIDTH{1'b1}}, {M_WIDTH{1'b0}}};
          w_flg[FLG_OVF] = 1'b1;
          w_flg[FLG_INX] = 1'b1;
        end else if (w_exp_rnd <= 0) begin
          w_res = {r1_sign, {(D_WIDTH-1){1'b0}}};
          w_flg[FLG_UNF] = 1'b1;
          w_flg[FLG_INX] = 1'b1;
        end else begin
          w_res = {r1_sign, w_exp_rnd[E_WIDTH-1:0], w_mant_rnd};
          w_flg[FLG_INX] = w_inx;
        end
      end
    endcase
  end

  logic [D_WIDTH-1:0] r2_result;
  logic [3:0]         r2_flags;

  always_ff @(posedge clk) begin
    if (rst) begin
      r2_valid  <= 1'b0;
      r2_result <= '0;
      r2_flags  <= '0;
    end else if (w_s2_adv) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_result <= w_res;
        r2_flags  <= w_flg;
      end
    end
  end

  assign out_result = r2_result;
  assign out_flags  = r2_flags;

endmodule

// File: tb/tb_fp32_mul_round_pack.sv
// Bench for fp32_mul_round_pack: directed corner cases plus random
// traffic with back-pressure checked against an arithmetic reference.
module tb_fp32_mul_round_pack;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic               in_sign;
  logic signed [9:0]  in_exp;
  logic [47:0]        in_prod;
  logic [1:0]         a_cls;
  logic [1:0]         b_cls;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_result;
  logic [3:0]         out_flags;

  int total = 0;
  int bad   = 0;

  fp32_mul_round_pack dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_prod   (in_prod),
    .a_cls     (a_cls),
    .b_cls     (b_cls),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  // Returns {flags, result}; rounding done on integer quotient/remainder.
  function automatic logic [35:0] model(
    input logic s, input int e_in, input logic [47:0] p,
    input logic [1:0] a, input logic [1:0] b);
    longint unsigned pr, q, rem, half;
    int sh, e;
    logic [3:0] f;
    logic [31:0] r;
    f = 4'b0;
    if (a == 2'b11 || b == 2'b11) begin
      r = 32'h7FC00000;
    end else if ((a == 2'b10 && b == 2'b01) ||
                 (a == 2'b01 && b == 2'b10)) begin
      r = 32'h7FC00000;
      f = 4'b1000;
    end else if (a == 2'b10 || b == 2'b10) begin
      r = {s, 8'hFF, 23'h0};
    end else if (a == 2'b01 || b == 2'b01) begin
      r = {s, 31'h0};
    end else begin
      pr   = 64'(p);
      sh   = p[47] ? 24 : 23;
      e    = e_in + (p[47] ? 1 : 0);
      q    = pr >> sh;
      rem  = pr - (q << sh);
      half = 64'h1 << (sh - 1);
      if (rem != 0) f[0] = 1'b1;
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'h1 << 24)) begin
        q = 64'h1 << 23;
        e = e + 1;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'h0};
        f = 4'b0101;
      end else if (e <= 0) begin
        r = {s, 31'h0};
        f = 4'b0011;
      end else begin
        r = {s, 8'(e), q[22:0]};
      end
    end
    return {f, r};
  endfunction

  task automatic rand_item(output logic s, output logic signed [9:0] e,
                           output logic [47:0] p, output logic [1:0] a,
                           output logic [1:0] b);
    logic [47:0] m1, m2;
    int ei;
    m1 = 48'({1'b1, 23'($urandom)});
    m2 = 48'({1'b1, 23'($urandom)});
    case ($urandom_range(0, 3))
      0, 1: p = m1 * m2;
      2: begin
        p = 48'({$urandom, $urandom});
        if (!p[47]) p[46] = 1'b1;
      end
      default: p = (m1 << 23) | (48'h1 << 22);
    endcase
    case ($urandom_range(0, 3))
      0: ei = int'($urandom_range(0, 4)) - 2;
      1: ei = int'($urandom_range(250, 256));
      default: ei = int'($urandom_range(0, 510)) - 127;
    endcase
    e = 10'(ei);
    s = 1'($urandom);
    a = ($urandom_range(0, 7) < 6) ? 2'b00 : 2'($urandom);
    b = ($urandom_range(0, 7) < 6) ? 2'b00 : 2'($urandom);
  endtask

  // Single transfer into an empty pipe; reports result and latency.
  task automatic xact(input logic s, input int e, input logic [47:0] p,
                      input logic [1:0] a, input logic [1:0] b,
                      output logic [31:0] res, output logic [3:0] flg,
                      output int lat);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sign   = s;
    in_exp    = 10'(e);
    in_prod   = p;
    a_cls     = a;
    b_cls     = b;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = out_result;
    flg = out_flags;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0)
      $display("FAIL rst_valid: got %b want 0", out_valid);
    if (out_valid !== 1'b0) bad++;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_ready: got %b want 1", in_ready);
    end
    total++;
    if (out_result !== 32'h0 || out_flags !== 4'h0) begin
      bad++;
      $display("FAIL rst_data: got %h/%b want 0/0",
               out_result, out_flags);
    end
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [47:0] p[10];
    int          e[10];
    logic        s[10];
    logic [1:0]  a[10], b[10];
    logic [31:0] wr[10];
    logic [3:0]  wf[10];
    string       nm[10];
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    p[0]=48'h900000000000; e[0]=127; s[0]=0; wr[0]=32'h40100000;
    wf[0]=4'b0000; nm[0]="basic";
    p[1]=48'h400000400000; e[1]=127; s[1]=0; wr[1]=32'h3F800000;
    wf[1]=4'b0001; nm[1]="rne_tie_even";
    p[2]=48'h400000C00000; e[2]=127; s[2]=0; wr[2]=32'h3F800002;
    wf[2]=4'b0001; nm[2]="rne_tie_odd";
    p[3]=48'h7FFFFFC00000; e[3]=127; s[3]=0; wr[3]=32'h40000000;
    wf[3]=4'b0001; nm[3]="round_carry";
    p[4]=48'h800000000000; e[4]=254; s[4]=0; wr[4]=32'h7F800000;
    wf[4]=4'b0101; nm[4]="overflow";
    p[5]=48'h400000000000; e[5]=0; s[5]=1; wr[5]=32'h80000000;
    wf[5]=4'b0011; nm[5]="underflow";
    p[6]=48'h400000000000; e[6]=1; s[6]=1; wr[6]=32'h80800000;
    wf[6]=4'b0000; nm[6]="min_normal";
    p[7]=48'h400000000000; e[7]=254; s[7]=0; wr[7]=32'h7F000000;
    wf[7]=4'b0000; nm[7]="max_exp";
    p[8]=48'h400000000000; e[8]=-127; s[8]=0; wr[8]=32'h00000000;
    wf[8]=4'b0011; nm[8]="deep_underflow";
    p[9]=48'hFFFFFFFFFFFF; e[9]=383; s[9]=1; wr[9]=32'hFF800000;
    wf[9]=4'b0101; nm[9]="deep_overflow";
    for (int i = 0; i < 10; i++) begin
      a[i] = 2'b00;
      b[i] = 2'b00;
      xact(s[i], e[i], p[i], a[i], b[i], r, f, lat);
      total++;
      if (r !== wr[i] || f !== wf[i] || lat != 2) begin
        bad++;
        $display("FAIL %s: got %h/%b lat=%0d want %h/%b lat=2",
                 nm[i], r, f, lat, wr[i], wf[i]);
      end
    end
  endtask

  task automatic test_specials;
    logic [1:0]  a[6], b[6];
    logic        s[6];
    logic [31:0] wr[6];
    logic [3:0]  wf[6];
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    a[0]=2'b10; b[0]=2'b01; s[0]=0; wr[0]=32'h7FC00000; wf[0]=4'b1000;
    a[1]=2'b11; b[1]=2'b00; s[1]=0; wr[1]=32'h7FC00000; wf[1]=4'b0000;
    a[2]=2'b01; b[2]=2'b10; s[2]=1; wr[2]=32'h7FC00000; wf[2]=4'b1000;
    a[3]=2'b10; b[3]=2'b00; s[3]=1; wr[3]=32'hFF800000; wf[3]=4'b0000;
    a[4]=2'b00; b[4]=2'b01; s[4]=1; wr[4]=32'h80000000; wf[4]=4'b0000;
    a[5]=2'b10; b[5]=2'b11; s[5]=1; wr[5]=32'h7FC00000; wf[5]=4'b0000;
    for (int i = 0; i < 6; i++) begin
      xact(s[i], 254, 48'h800000000000, a[i], b[i], r, f, lat);
      total++;
      if (r !== wr[i] || f !== wf[i] || lat != 2) begin
        bad++;
        $display("FAIL special_%0d: got %h/%b lat=%0d want %h/%b",
                 i, r, f, lat, wr[i], wf[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [35:0] ex[6];
    logic        s;
    logic signed [9:0] e;
    logic [47:0] p;
    logic [1:0]  a, b;
    logic        want_v;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 11; cyc++) begin
      in_valid = (cyc < 6);
      if (cyc < 6) begin
        rand_item(s, e, p, a, b);
        in_sign = s; in_exp = e; in_prod = p; a_cls = a; b_cls = b;
        ex[cyc] = model(s, int'(e), p, a, b);
      end
      #1;
      if (cyc < 6) begin
        total++;
        if (in_ready !== 1'b1) begin
          bad++;
          $display("FAIL b2b_ready: cyc=%0d got %b want 1",
                   cyc, in_ready);
        end
      end
      want_v = (cyc >= 2 && cyc < 8);
      total++;
      if (out_valid !== want_v ||
          (want_v && {out_flags, out_result} !== ex[cyc-2])) begin
        bad++;
        $display("FAIL b2b_out: cyc=%0d got v=%b %h want v=%b %h",
                 cyc, out_valid, {out_flags, out_result}, want_v,
                 want_v ? ex[cyc-2] : 36'h0);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    logic [35:0] ex[4];
    logic        s[4];
    logic signed [9:0] e[4];
    logic [47:0] p[4];
    logic [1:0]  a[4], b[4];
    logic [31:0] held;
    int ni, no;
    ni = 0;
    no = 0;
    held = '0;
    for (int i = 0; i < 4; i++) begin
      rand_item(s[i], e[i], p[i], a[i], b[i]);
      ex[i] = model(s[i], int'(e[i]), p[i], a[i], b[i]);
    end
    for (int cyc = 0; cyc < 40 && no < 4; cyc++) begin
      out_ready = (cyc >= 6);
      in_valid  = (ni < 4);
      if (ni < 4) begin
        in_sign = s[ni]; in_exp = e[ni]; in_prod = p[ni];
        a_cls = a[ni]; b_cls = b[ni];
      end
      #1;
      if (cyc == 2) held = out_result;
      if (cyc == 5) begin
        total++;
        if (in_ready !== 1'b0 || ni != 2) begin
          bad++;
          $display("FAIL bp_stall: in_ready=%b accepts=%0d want 0/2",
                   in_ready, ni);
        end
        total++;
        if (out_valid !== 1'b1 || out_result !== held ||
            out_result !== ex[0][31:0]) begin
          bad++;
          $display("FAIL bp_hold: got v=%b %h want v=1 %h",
                   out_valid, out_result, ex[0][31:0]);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if ({out_flags, out_result} !== ex[no]) begin
          bad++;
          $display("FAIL bp_order_%0d: got %h want %h",
                   no, {out_flags, out_result}, ex[no]);
        end
        no++;
      end
      if (in_valid && in_ready) ni++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++;
    if (no != 4) begin
      bad++;
      $display("FAIL bp_count: got %0d want 4", no);
    end
    repeat (3) @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_dup: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_midflight;
    logic seen;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sign = 1'b0; in_exp = 10'sd127;
    in_prod = 48'h900000000000; a_cls = 2'b00; b_cls = 2'b00;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_full: got v=%b rdy=%b want 1/0",
               out_valid, in_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_rst: got v=%b rdy=%b want 0/1",
               out_valid, in_ready);
    end
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL mid_drop: got stray output want none");
    end
  endtask

  task automatic test_random;
    localparam int N = 400;
    logic [35:0] q[$];
    int sent, got;
    sent = 0;
    got  = 0;
    fork
      begin
        logic s;
        logic signed [9:0] e;
        logic [47:0] p;
        logic [1:0] a, b;
        for (int cyc = 0; cyc < 6000 && sent < N; cyc++) begin
          rand_item(s, e, p, a, b);
          in_valid = ($urandom_range(0, 3) != 0);
          in_sign = s; in_exp = e; in_prod = p;
          a_cls = a; b_cls = b;
          #1;
          if (in_valid && in_ready) begin
            q.push_back(model(s, int'(e), p, a, b));
            sent++;
          end
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin
        logic [35:0] w;
        for (int cyc = 0; cyc < 6000 && got < N; cyc++) begin
          out_ready = ($urandom_range(0, 3) != 0);
          #1;
          if (out_valid && out_ready) begin
            total++;
            w = (q.size() != 0) ? q.pop_front() : 36'hX;
            if ({out_flags, out_result} !== w) begin
              bad++;
              $display("FAIL rand_%0d: got %h want %h",
                       got, {out_flags, out_result}, w);
            end
            got++;
          end
          @(negedge clk);
        end
      end
    join
    total++;
    if (got != N || sent != N) begin
      bad++;
      $display("FAIL rand_count: sent=%0d got=%0d want %0d",
               sent, got, N);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_prod   = '0;
    a_cls     = 2'b00;
    b_cls     = 2'b00;
    out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_specials();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp32_mul_round_pack.md
Name: fp32_mul_round_pack

Overview:
Downstream stage of the single-precision multiplier datapath. It consumes the raw 48-bit significand product, the biased exponent sum and the combined sign, then normalizes, rounds to nearest-even and handles overflow, underflow and special operands. It emits a packed IEEE-754 binary32 result with exception flags. It is a 2-stage valid/ready pipeline so the multiplier front end can be registered and back-pressured.

Parameters:
D_WIDTH, 32, packed result width
E_WIDTH, 8, exponent field width
M_WIDTH, 23, stored mantissa width
P_WIDTH, 48, significand product width, equal to 2*(M_WIDTH+1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream product valid
in_ready  output  1  stage can accept the product this cycle
in_sign  input  1  sign1 ^ sign2
in_exp  input  E_WIDTH+2  signed two's-complement exp1+exp2-127; range -127..383
in_prod  input  P_WIDTH  {1,m1}*{1,m2}; bit 47 or bit 46 is set for normal operands
a_cls  input  2  operand A class: 00 normal, 01 zero (includes denormal), 10 inf, 11 NaN
b_cls  input  2  operand B class, same encoding
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
out_result  output  D_WIDTH  packed {sign, exponent, mantissa}
out_flags  output  4  {invalid, overflow, underflow, inexact}

Behaviour:
- Reset: rst sampled high at a clk edge clears both stage valid bits. After reset, out_valid=0, out_result=0, out_flags=0 and in_ready=1. Reset mid-flight drops in-flight data with no partial output.
- Handshake: a transfer occurs when valid&&ready on a port. Stage 2 advances when !s2_valid || out_ready. Stage 1 advances when !s1_valid || stage 2 advances. in_ready equals the stage-1 advance condition (combinational). No bubbles are inserted under full throughput.
- Latency: 2 cycles from input accept to out_valid when out_ready=1. Throughput is 1 per cycle.
- While out_valid=1 && out_ready=0, out_result and out_flags hold stable.
- Stage 1 (normalize):
  - If prod[47]=1: mant=prod[46:24], G=prod[23], S=|prod[22:0], e=in_exp+1.
  - Else: mant=prod[45:23], G=prod[22], S=|prod[21:0], e=in_exp.
  - Register sign, e, mant, G, S and the special class (NaN / inf / zero / normal).
- Stage 2 (round/pack):
  - Round up when G && (S || mant[0]); inexact = G|S.
  - If the mant+1 carry leaves 23 bits: mant=0, e=e+1.
  - After rounding, evaluate in order:
    - e >= 255: result is {sign, 8'hFF, 0}; set overflow and inexact.
    - e <= 0: result is {sign, 0, 0} (flush-to-zero, no subnormals); set underflow and inexact.
    - Otherwise: result is {sign, e[7:0], mant}.
- Specials override the arithmetic path and set no flags except where stated:
  - Any NaN operand, or inf*zero: result 32'h7FC00000. inf*zero also sets invalid.
  - inf*(normal|inf): {sign, 8'hFF, 0}.
  - zero*(normal|zero): {sign, 0, 0}.
- Widths: all exponent arithmetic is signed E_WIDTH+2 bits, with no wrap across the -127..384 range.

Decomposition:
- Package fp32_pkg holds:
  - the class encodings (CLS_NORMAL, CLS_ZERO, CLS_INF, CLS_NAN);
  - BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000;
  - the flag bit indices.
- One combinational sub-module, fp_round_rne: input {mant, G, S}, output {mant_rounded, carry, inexact}. It is instantiated in stage 2 and reusable by the adder datapath.

Test Plan:
- Basic product: in_exp=127, prod=48'h900000000000, sign 0, both cls 00 -> 2 cycles later out_result=32'h40100000 (2.25), flags 0.
- RNE tie: in_exp=127, prod=48'h400000400000 -> 32'h3F800000, inexact=1. prod=48'h400000C00000 -> 32'h3F800002, inexact=1.
- Rounding carry: in_exp=127, prod=48'h7FFFFFC00000 -> 32'h40000000, inexact=1.
- Overflow/underflow:
  - in_exp=254, prod=48'h800000000000 -> 32'h7F800000, overflow+inexact.
  - in_exp=0, prod=48'h400000000000, sign 1 -> 32'h80000000, underflow+inexact.
- Specials: a_cls=10, b_cls=01 -> 32'h7FC00000, invalid=1. a_cls=11, b_cls=00 -> 32'h7FC00000, flags 0.
- Backpressure and reset:
  - Stream 4 products with out_ready held 0 -> in_ready drops after 2 accepts and out_result stays stable.
  - Release out_ready -> all 4 results appear in order with no loss or duplication.
  - Assert rst with both stages full -> next cycle out_valid=0, in_ready=1.
